// File: rtl/proto_isa_pkg.sv
// ProtoCore ISA definitions shared by the sequencer and its decoder:
// opcodes, instruction classes, field positions and FSM states.
package proto_isa_pkg;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluNot = 3'b101;
  localparam logic [2:0] AluShl = 3'b110;
  localparam logic [2:0] AluShr = 3'b111;

  // Any class with bit 3 clear is an ALU instruction.
  localparam logic [3:0] ClsLdi  = 4'b1000;
  localparam logic [3:0] ClsJmp  = 4'b1001;
  localparam logic [3:0] ClsJz   = 4'b1010;
  localparam logic [3:0] ClsJc   = 4'b1011;
  localparam logic [3:0] ClsHalt = 4'b1111;

  localparam int unsigned ClsMsb = 15;
  localparam int unsigned ClsLsb = 12;
  localparam int unsigned OpMsb  = 14;
  localparam int unsigned OpLsb  = 12;
  localparam int unsigned RdMsb  = 11;
  localparam int unsigned RdLsb  = 8;
  localparam int unsigned RaMsb  = 7;
  localparam int unsigned RaLsb  = 4;
  localparam int unsigned RbMsb  = 3;
  localparam int unsigned RbLsb  = 0;
  localparam int unsigned ImmMsb = 7;
  localparam int unsigned ImmLsb = 0;

  typedef enum logic [1:0] {
    StFetch  = 2'd0,
    StDecode = 2'd1,
    StExec   = 2'd2,
    StHalt   = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [2:0] alu_opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] wa;
    logic [7:0] imm;
    logic       is_alu;
    logic       is_ldi;
    logic       is_jmp;
    logic       is_jz;
    logic       is_jc;
    logic       is_halt;
  } decode_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits an instruction word into register
// file control fields and one-hot class flags.
module instr_decoder
  import proto_isa_pkg::*;
(
  input  logic [15:0] ir_i,
  output decode_t     dec_o
);

  logic [3:0] cls;

  assign cls = ir_i[ClsMsb:ClsLsb];

  always_comb begin
    dec_o = '0;
    if (!cls[3]) begin
      dec_o.is_alu     = 1'b1;
      dec_o.alu_opcode = ir_i[OpMsb:OpLsb];
      dec_o.wa         = ir_i[RdMsb:RdLsb];
      dec_o.ra         = ir_i[RaMsb:RaLsb];
      dec_o.rb         = ir_i[RbMsb:RbLsb];
    end else begin
      unique case (cls)
        ClsLdi: begin
          dec_o.is_ldi = 1'b1;
          dec_o.wa     = ir_i[RdMsb:RdLsb];
          dec_o.imm    = ir_i[ImmMsb:ImmLsb];
        end
        ClsJmp:  dec_o.is_jmp  = 1'b1;
        ClsJz:   dec_o.is_jz   = 1'b1;
        ClsJc:   dec_o.is_jc   = 1'b1;
        ClsHalt: dec_o.is_halt = 1'b1;
        default: ; // remaining classes are NOPs
      endcase
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute controller for the ProtoCore datapath. Owns pc, ir,
// the zero/carry flags and the FSM; field decode lives in instr_decoder.
module ctrl_sequencer
  import proto_isa_pkg::*;
#(
  parameter int unsigned        PC_W     = 8,
  parameter logic [PC_W-1:0]    RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_valid,
  input  logic            alu_zero,
  input  logic            alu_carry,
  output logic            alu_en,
  output logic [2:0]      alu_opcode,
  output logic [3:0]      ra_addr,
  output logic [3:0]      rb_addr,
  output logic [3:0]      write_addr,
  output logic [7:0]      imm_value,
  output logic            write_en,
  output logic            halted
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            z_flag_q, z_flag_d;
  logic            c_flag_q, c_flag_d;

  decode_t         dec;
  logic            fetch_fire;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;

  instr_decoder u_instr_decoder (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

  assign fetch_fire    = imem_req && imem_valid;
  assign branch_target = PC_W'(ir_q[ImmMsb:ImmLsb]);
  assign branch_taken  = dec.is_jmp || (dec.is_jz && z_flag_q) || (dec.is_jc && c_flag_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (fetch_fire) state_d = StDecode;
      StDecode: state_d = dec.is_halt ? StHalt : StExec;
      StExec:   state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
  end

  // Reset gates the request and address so outputs go quiet without a clock.
  always_comb begin
    imem_req   = (state_q == StFetch) && !rst;
    imem_addr  = rst ? '0 : pc_q;
    halted     = (state_q == StHalt);
    write_en   = (state_q == StExec) && (dec.is_alu || dec.is_ldi);
    alu_en     = (state_q == StExec) && dec.is_alu;
    alu_opcode = dec.alu_opcode;
    ra_addr    = dec.ra;
    rb_addr    = dec.rb;
    write_addr = dec.wa;
    imm_value  = dec.imm;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      z_flag_q <= 1'b0;
      c_flag_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      z_flag_q <= z_flag_d;
      c_flag_q <= c_flag_d;
    end
  end

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    z_flag_d = z_flag_q;
    c_flag_d = c_flag_q;
    if (fetch_fire) begin
      ir_d = imem_rdata;
      pc_d = pc_q + PC_W'(1);
    end
    if (state_q == StExec) begin
      if (dec.is_alu) begin
        z_flag_d = alu_zero;
        c_flag_d = alu_carry;
      end
      if (branch_taken) begin
        pc_d = branch_target;
      end
    end
  end

endmodule
